// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a synchronous FIFO that has a one-cycle read latency and presents its
// words as a valid/ready stream. A 2-entry output buffer hides the read latency,
// so the block sustains one word per cycle while m_ready stays high.
// m_last marks the final word of every FRAME_LEN-word block.
//
// Handshake: a word transfers on any rising clk edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, m_data and m_last hold stable.
// m_valid never depends on m_ready.
module fifo_stream_reader #(
    parameter int BIT_WIDTH = 8,
    parameter int FRAME_LEN = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    output logic                 fifo_re,
    input  logic [BIT_WIDTH-1:0] fifo_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BIT_WIDTH-1:0] m_data,
    output logic                 m_last
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);

    // Output buffer: two word slots with head/tail pointers and an occupancy count.
    logic [BIT_WIDTH-1:0] r_buf [2];
    logic                 r_head;
    logic                 r_tail;
    logic [1:0]           r_count;

    // High during the cycle in which fifo_dout carries a word we asked for.
    logic                 r_rd_pend;

    // Position of the current head word inside its FRAME_LEN block.
    logic [CNT_W-1:0]     r_beat_cnt;

    logic                 w_pop;
    logic                 w_rd_accept;
    logic [2:0]           w_occ;

    assign m_valid = (r_count != 2'd0);
    assign m_data  = r_buf[r_head];
    assign m_last  = m_valid && (r_beat_cnt == LAST_BEAT);

    // Read issue: only request a word if the buffer is sure to have a slot for it
    // once it arrives, counting the word already in flight and this cycle's pop.
    always_comb begin
        w_pop       = m_valid && m_ready;
        w_occ       = {1'b0, r_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};
        fifo_re     = n_rst && en && !fifo_empty && (w_occ < 3'd2);
        w_rd_accept = fifo_re && !fifo_empty;
    end

    // Track whether fifo_dout holds a requested word in the next cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_accept;
        end
    end

    // Capture arriving words at the tail and retire accepted words from the head.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_rd_pend) begin
                r_buf[r_tail] <= fifo_dout;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

    // Count delivered words within the block, wrapping after the last one.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            if (r_beat_cnt == LAST_BEAT) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + BEAT_ONE;
            end
        end
    end

endmodule
